// File: rtl/game_tick_ctrl.sv
// rtl/game_tick_ctrl.sv - game frame/animation tick generator; GAME_SPEEDUP_EN adds the level speed ramp
module game_tick_ctrl #(
    parameter logic [31:0] BASE_PERIOD  = 32'd1_000_000,
    parameter logic [31:0] STEP         = 32'd50_000,
    parameter logic [31:0] MIN_PERIOD   = 32'd250_000,
    parameter logic [15:0] LEVEL_FRAMES = 16'd600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pause,
    input  logic        stop,
    output logic        frame_tick,
    output logic        anim_tick,
    output logic [3:0]  level,
    output logic [1:0]  state,
    output logic [31:0] period
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    state_t      st;
    logic [31:0] cnt;
    logic [2:0]  anim_cnt;

    // Only the highest-priority pulse on an edge is acted on.
    logic ev_stop;
    logic ev_pause;
    logic ev_start;
    assign ev_stop  = stop;
    assign ev_pause = pause & ~stop;
    assign ev_start = start & ~pause & ~stop;

    // cnt only moves while running with no stop/pause on the edge.
    logic run_edge;
    logic wrap;
    logic game_begin;
    assign run_edge   = (st == ST_RUN) && !stop && !pause;
    assign wrap       = run_edge && (cnt == period - 32'd1);
    assign game_begin = ((st == ST_IDLE) || (st == ST_OVER)) && ev_start;

    assign state = st;

    // Game state machine, frame counter and registered tick pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= ST_IDLE;
            cnt        <= 32'd0;
            anim_cnt   <= 3'd0;
            frame_tick <= 1'b0;
            anim_tick  <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            anim_tick  <= 1'b0;
            case (st)
                ST_IDLE, ST_OVER: begin
                    cnt <= 32'd0;
                    if (ev_start) begin
                        st       <= ST_RUN;
                        anim_cnt <= 3'd0;
                    end
                end
                ST_RUN: begin
                    if (ev_stop) begin
                        st  <= ST_OVER;
                        cnt <= 32'd0;
                    end else if (ev_pause) begin
                        st <= ST_PAUSE;
                    end else if (wrap) begin
                        cnt        <= 32'd0;
                        frame_tick <= 1'b1;
                        anim_cnt   <= anim_cnt + 3'd1;
                        anim_tick  <= (anim_cnt == 3'd7);
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_PAUSE: begin
                    if (ev_stop) begin
                        st  <= ST_OVER;
                        cnt <= 32'd0;
                    end else if (ev_pause) begin
                        st <= ST_RUN;
                    end
                end
            endcase
        end
    end

`ifdef GAME_SPEEDUP_EN
    logic [15:0] frame_cnt;
    logic [31:0] next_period;

    // Period after a level-up: step down but never below MIN_PERIOD or through zero.
    always_comb begin
        next_period = MIN_PERIOD;
        if ((period >= STEP) && (period - STEP >= MIN_PERIOD)) begin
            next_period = period - STEP;
        end
    end

    // Level ramp: every LEVEL_FRAMES frames raise the level and shorten the period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'd0;
            level     <= 4'd0;
            period    <= BASE_PERIOD;
        end else if (game_begin) begin
            frame_cnt <= 16'd0;
            level     <= 4'd0;
            period    <= BASE_PERIOD;
        end else if (wrap) begin
            if (frame_cnt + 16'd1 == LEVEL_FRAMES) begin
                frame_cnt <= 16'd0;
                period    <= next_period;
                if (level != 4'd15) begin
                    level <= level + 4'd1;
                end
            end else begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_begin;
    assign unused_begin = game_begin;
    assign level  = 4'd0;
    assign period = BASE_PERIOD;
`endif

endmodule

// File: tb/tb_game_tick_ctrl.sv
// tb/tb_game_tick_ctrl.sv - randomized self-checking bench for game_tick_ctrl against a frame-count model
module tb_game_tick_ctrl;

    localparam logic [31:0] BASE = 32'd10;
    localparam logic [31:0] STP  = 32'd2;
    localparam logic [31:0] MINP = 32'd4;
    localparam logic [15:0] LF   = 16'd3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        stop  = 1'b0;
    logic        frame_tick;
    logic        anim_tick;
    logic [3:0]  level;
    logic [1:0]  state;
    logic [31:0] period;

    int checks = 0;
    int errors = 0;

    // Model: state code, cycles elapsed in the current frame, frames since game start.
    int m_st;
    int m_elapsed;
    int m_frames;
    bit m_ft;
    bit m_at;

    always #5 clk = ~clk;

    game_tick_ctrl #(
        .BASE_PERIOD  (BASE),
        .STEP         (STP),
        .MIN_PERIOD   (MINP),
        .LEVEL_FRAMES (LF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pause      (pause),
        .stop       (stop),
        .frame_tick (frame_tick),
        .anim_tick  (anim_tick),
        .level      (level),
        .state      (state),
        .period     (period)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int level_ups(input int frames);
        return frames / int'(LF);
    endfunction

    function automatic int exp_period(input int frames);
        int p;
`ifdef GAME_SPEEDUP_EN
        p = int'(BASE) - int'(STP) * level_ups(frames);
        if (p < int'(MINP)) p = int'(MINP);
`else
        p = int'(BASE);
`endif
        return p;
    endfunction

    function automatic int exp_level(input int frames);
`ifdef GAME_SPEEDUP_EN
        return (level_ups(frames) > 15) ? 15 : level_ups(frames);
`else
        return 0;
`endif
    endfunction

    task automatic model_reset;
        m_st      = 0;
        m_elapsed = 0;
        m_frames  = 0;
        m_ft      = 1'b0;
        m_at      = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit t);
        bit was_run;
        was_run = (m_st == 1);
        m_ft = 1'b0;
        m_at = 1'b0;
        if (t) begin
            if (m_st == 1 || m_st == 2) begin
                m_st      = 3;
                m_elapsed = 0;
            end
        end else if (p) begin
            if (m_st == 1) m_st = 2;
            else if (m_st == 2) m_st = 1;
        end else if (s) begin
            if (m_st == 0 || m_st == 3) begin
                m_st      = 1;
                m_elapsed = 0;
                m_frames  = 0;
            end
        end
        if (was_run && !t && !p) begin
            m_elapsed++;
            if (m_elapsed == exp_period(m_frames)) begin
                m_elapsed = 0;
                m_frames++;
                m_ft = 1'b1;
                m_at = (m_frames % 8 == 0);
            end
        end
    endtask

    task automatic compare_all;
        check("state",      {30'd0, state},      32'(m_st));
        check("frame_tick", {31'd0, frame_tick}, {31'd0, m_ft});
        check("anim_tick",  {31'd0, anim_tick},  {31'd0, m_at});
        check("level",      {28'd0, level},      32'(exp_level(m_frames)));
        check("period",     period,              32'(exp_period(m_frames)));
    endtask

    // Called at a falling edge: drive pulses, take one rising edge, compare at the next falling edge.
    task automatic cycle(input bit s, input bit p, input bit t);
        start = s;
        pause = p;
        stop  = t;
        @(posedge clk);
        model_step(s, p, t);
        @(negedge clk);
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
        compare_all();
    endtask

    initial begin
        int n;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Plain start and free run: ticks every 10 edges, anim tick on 8th frame.
        cycle(1, 0, 0);
        repeat (90) cycle(0, 0, 0);

        // Pause mid-frame at elapsed 5, hold 20 cycles, resume.
        cycle(1, 0, 0);
        n = 0;
        while (!m_ft && n < 100) begin cycle(0, 0, 0); n++; end
        check("wait_tick_a", {31'd0, frame_tick}, 32'd1);
        repeat (5) cycle(0, 0, 0);
        cycle(0, 1, 0);
        repeat (20) cycle(0, 0, 0);
        cycle(0, 1, 0);
        repeat (12) cycle(0, 0, 0);

        // Long run to reach minimum period and level saturation.
        repeat (400) cycle(0, 0, 0);

        // Stop exactly on the terminal-count edge, idle in OVER, then restart.
        n = 0;
        while (!(m_st == 1 && m_elapsed == exp_period(m_frames) - 1) && n < 100) begin
            cycle(0, 0, 0);
            n++;
        end
        check("wait_term", {30'd0, state}, 32'd1);
        cycle(0, 0, 1);
        repeat (6) cycle(0, 0, 0);
        cycle(1, 0, 0);
        repeat (40) cycle(0, 0, 0);

        // Asynchronous reset between edges right after a tick.
        n = 0;
        while (!m_ft && n < 100) begin cycle(0, 0, 0); n++; end
        check("wait_tick_b", {31'd0, frame_tick}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_state",  {30'd0, state},      32'd0);
        check("async_ftick",  {31'd0, frame_tick}, 32'd0);
        check("async_atick",  {31'd0, anim_tick},  32'd0);
        check("async_level",  {28'd0, level},      32'd0);
        check("async_period", period,              BASE);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
        cycle(1, 0, 0);
        repeat (30) cycle(0, 0, 0);

        // Random pulse mix, including simultaneous pulses.
        repeat (3000) begin
            cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 79) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
